sorted_streamer: RTL and testbench

Output-side companion to `parallelsort`. It captures the sorter's 8-element `sorted_array` when the sorter's `ready` rises. It then streams the elements one per transfer over a valid/ready handshake, lowest index first. While capturing, it checks that the array is actually sorted.

---
 rtl/sort_pkg.sv | 14 +
 rtl/sorted_streamer_if.sv | 34 +++
 rtl/sort_order_check.sv | 22 ++
 rtl/sorted_streamer.sv | 116 +++++++++++
 tb/tb_sorted_streamer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizes for the parallel sorter, its output streamer and their benches.
package sort_pkg;

  localparam int SORT_WIDTH = 8;
  localparam int SORT_N     = 8;

  typedef logic [SORT_WIDTH-1:0] elem_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/sorted_streamer_if.sv
// Element stream leaving sorted_streamer: one array element per valid/ready transfer.
// Handshake: a transfer happens on a rising clk edge where out_valid & out_ready are both 1;
// while out_valid=1 and out_ready=0 the master holds out_data/out_index/out_last stable,
// and out_valid never depends combinationally on out_ready.
interface sorted_streamer_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);

  localparam int IW = $clog2(N);

  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_index;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sort_order_check.sv
// Combinational ordering check over adjacent pairs of an array; equal neighbours are legal.
module sort_order_check #(
  parameter int WIDTH      = 8,
  parameter int N          = 8,
  parameter bit DESCENDING = 1'b0
) (
  input  logic [WIDTH-1:0] i_arr [N],
  output logic             err
);

  always_comb begin
    err = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (DESCENDING) begin
        if (i_arr[i] < i_arr[i+1]) err = 1'b1;
      end else begin
        if (i_arr[i] > i_arr[i+1]) err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorted_streamer.sv
// Captures a sorted array on the rising edge of sort_ready, checks its ordering,
// then streams the elements lowest index first over a valid/ready interface.
module sorted_streamer
  import sort_pkg::*;
#(
  parameter int WIDTH      = SORT_WIDTH,
  parameter int N          = SORT_N,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      sorted_array [N],
  input  logic                  sort_ready,
  sorted_streamer_if.master     o_out,
  output logic                  busy,
  output logic                  order_err,
  output logic                  overrun,
  output logic                  done,
  output stream_state_t         o_dbg_state
);

  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  stream_state_t    r_state;
  stream_state_t    w_state_nxt;
  logic             r_sort_ready_q;
  logic             w_rise;
  logic             w_capture;
  logic             w_fire;
  logic             w_last_fire;
  logic             w_stream;
  logic             w_order_err;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_buf [N];
  logic             r_order_err;
  logic             r_overrun;
  logic             r_done;

  assign w_rise   = sort_ready & ~r_sort_ready_q;
  assign w_stream = (r_state == STREAM);

  sort_order_check #(
    .WIDTH      (WIDTH),
    .N          (N),
    .DESCENDING (DESCENDING)
  ) u_order_check (
    .i_arr (sorted_array),
    .err   (w_order_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_fire      = 1'b0;
    w_last_fire = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_fire = o_out.out_ready;
        if (w_fire && (r_idx == LAST_IDX)) begin
          w_last_fire = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_sort_ready_q <= 1'b0;
      r_idx          <= '0;
      r_order_err    <= 1'b0;
      r_overrun      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_sort_ready_q <= sort_ready;
      r_done         <= w_last_fire;
      if (w_capture) begin
        r_idx       <= '0;
        r_order_err <= w_order_err;
      end else if (w_last_fire) begin
        r_idx <= '0;
      end else if (w_fire) begin
        r_idx <= r_idx + 1'b1;
      end
      // A new frame arriving mid-stream (including on the final transfer) is lost.
      if (w_rise && w_stream) r_overrun <= 1'b1;
    end
  end

  // Buffer intentionally has no reset; it is only read while streaming a captured frame.
  always_ff @(posedge clk) begin
    if (w_capture) r_buf <= sorted_array;
  end

  assign o_out.out_valid = w_stream;
  assign o_out.out_index = r_idx;
  assign o_out.out_data  = w_stream ? r_buf[r_idx] : '0;
  assign o_out.out_last  = w_stream && (r_idx == LAST_IDX);

  assign busy        = w_stream;
  assign order_err   = r_order_err;
  assign overrun     = r_overrun;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sorted_streamer.sv
// Bench for sorted_streamer: an ascending-check and a descending-check instance share stimulus;
// streams are compared against frames and ordering flags derived from a sort-based model.
module tb_sorted_streamer;
  import sort_pkg::*;

  localparam int W  = SORT_WIDTH;
  localparam int N  = SORT_N;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  sorted_array [N];
  logic          sort_ready;

  logic          busy_a, order_err_a, overrun_a, done_a;
  logic          busy_d, order_err_d, overrun_d, done_d;
  stream_state_t dbg_a, dbg_d;

  sorted_streamer_if #(.WIDTH(W), .N(N)) if_a ();
  sorted_streamer_if #(.WIDTH(W), .N(N)) if_d ();

  sorted_streamer #(.WIDTH(W), .N(N), .DESCENDING(1'b0)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .sorted_array (sorted_array),
    .sort_ready   (sort_ready),
    .o_out        (if_a),
    .busy         (busy_a),
    .order_err    (order_err_a),
    .overrun      (overrun_a),
    .done         (done_a),
    .o_dbg_state  (dbg_a)
  );

  sorted_streamer #(.WIDTH(W), .N(N), .DESCENDING(1'b1)) dut_d (
    .clk          (clk),
    .reset        (reset),
    .sorted_array (sorted_array),
    .sort_ready   (sort_ready),
    .o_out        (if_d),
    .busy         (busy_d),
    .order_err    (order_err_d),
    .overrun      (overrun_d),
    .done         (done_d),
    .o_dbg_state  (dbg_d)
  );

  assign if_d.out_ready = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int            pass_cnt = 0;
  int            chk_cnt  = 0;
  logic [W-1:0]  frame [N];
  logic [W-1:0]  asc_frame [N];
  logic [W-1:0]  desc_frame [N];
  logic [W-1:0]  exp_q [$];

  logic [W-1:0]  obs_data [$];
  int            obs_idx [$];
  logic          obs_last [$];
  int            obs_cyc [$];
  int            obs_hold_viol;
  int            obs_done_cnt;
  int            obs_end_cyc;
  logic          obs_done_end, obs_busy_end, obs_valid_end;

  // ---------------- reference model ----------------
  function automatic logic ref_err(input bit desc);
    logic [W-1:0] q [$];
    logic         e;
    for (int i = 0; i < N; i++) q.push_back(frame[i]);
    if (desc) q.rsort();
    else      q.sort();
    e = 1'b0;
    for (int i = 0; i < N; i++) if (q[i] != frame[i]) e = 1'b1;
    return e;
  endfunction

  function automatic void random_frame(input bit make_sorted);
    logic [W-1:0] q [$];
    for (int i = 0; i < N; i++) q.push_back(W'($urandom_range(0, (1 << W) - 1)));
    if (make_sorted) q.sort();
    for (int i = 0; i < N; i++) frame[i] = q[i];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at T+1 of the capture; sorted_array is scrambled afterwards.
  task automatic start_frame();
    sort_ready = 1'b0;
    tick();
    sorted_array = frame;
    sort_ready   = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(frame[i]);
    tick();
    for (int i = 0; i < N; i++) sorted_array[i] = W'($urandom_range(0, (1 << W) - 1));
  endtask

  // Sinks one frame from dut_a. mode 0: ready high, 1: 1,0,0 pattern, 2: random.
  // rise_at > 1 produces another sort_ready rise sampled at the end of that stream cycle.
  task automatic collect(input int mode, input int rise_at);
    int           c;
    logic         r;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    obs_data.delete(); obs_idx.delete(); obs_last.delete(); obs_cyc.delete();
    obs_hold_viol = 0;
    obs_done_cnt  = 0;
    prev_stall    = 1'b0;
    prev_data     = '0;
    prev_idx      = '0;
    c = 1;
    while (obs_data.size() < N && c < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((c - 1) % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if_a.out_ready = r;
      if (rise_at > 1 && c == rise_at - 1) sort_ready = 1'b0;
      if (rise_at > 1 && c == rise_at)     sort_ready = 1'b1;
      if (done_a === 1'b1) obs_done_cnt++;
      if (prev_stall && (if_a.out_data !== prev_data || if_a.out_index !== prev_idx))
        obs_hold_viol++;
      if (if_a.out_valid === 1'b1 && r) begin
        obs_data.push_back(if_a.out_data);
        obs_idx.push_back(int'(if_a.out_index));
        obs_last.push_back(if_a.out_last);
        obs_cyc.push_back(c);
      end
      prev_stall = (if_a.out_valid === 1'b1) && !r;
      prev_data  = if_a.out_data;
      prev_idx   = if_a.out_index;
      tick();
      c++;
    end
    obs_end_cyc   = c;
    obs_done_end  = done_a;
    obs_busy_end  = busy_a;
    obs_valid_end = if_a.out_valid;
    if (done_a === 1'b1) obs_done_cnt++;
    if_a.out_ready = 1'b0;
    tick();
    if (done_a === 1'b1) obs_done_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    sort_ready = 1'b0;
    if_a.out_ready = 1'b0;
    for (int i = 0; i < N; i++) sorted_array[i] = '0;
    repeat (3) tick();
    chk_cnt++; if (if_a.out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", if_a.out_valid); else pass_cnt++;
    chk_cnt++; if (if_a.out_last !== 1'b0) $display("FAIL rst_last: got %b expected 0", if_a.out_last); else pass_cnt++;
    chk_cnt++; if (if_a.out_index !== '0) $display("FAIL rst_index: got %0d expected 0", if_a.out_index); else pass_cnt++;
    chk_cnt++; if (if_a.out_data !== '0) $display("FAIL rst_data: got %0d expected 0", if_a.out_data); else pass_cnt++;
    chk_cnt++; if ({busy_a, order_err_a, overrun_a, done_a} !== 4'b0)
      $display("FAIL rst_flags: got %b expected 0000", {busy_a, order_err_a, overrun_a, done_a}); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ascending();
    frame = asc_frame;
    start_frame();
    chk_cnt++; if (busy_a !== 1'b1) $display("FAIL asc_busy: got %b expected 1", busy_a); else pass_cnt++;
    chk_cnt++; if (order_err_a !== 1'b0) $display("FAIL asc_err: got %b expected 0", order_err_a); else pass_cnt++;
    collect(0, 0);
    chk_cnt++; if (obs_data.size() != N) $display("FAIL asc_count: got %0d expected %0d", obs_data.size(), N); else pass_cnt++;
    for (int k = 0; k < obs_data.size(); k++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk_cnt++; if (obs_data[k] !== e) $display("FAIL asc_data[%0d]: got %0d expected %0d", k, obs_data[k], e); else pass_cnt++;
      chk_cnt++; if (obs_idx[k] != k) $display("FAIL asc_index[%0d]: got %0d expected %0d", k, obs_idx[k], k); else pass_cnt++;
      chk_cnt++; if (obs_last[k] !== (k == N - 1)) $display("FAIL asc_last[%0d]: got %b expected %b", k, obs_last[k], (k == N - 1)); else pass_cnt++;
      chk_cnt++; if (obs_cyc[k] != k + 1) $display("FAIL asc_cycle[%0d]: got T+%0d expected T+%0d", k, obs_cyc[k], k + 1); else pass_cnt++;
    end
    chk_cnt++; if (obs_end_cyc != N + 1 || obs_done_end !== 1'b1)
      $display("FAIL asc_done: got done=%b at T+%0d expected done=1 at T+%0d", obs_done_end, obs_end_cyc, N + 1); else pass_cnt++;
    chk_cnt++; if ({obs_busy_end, obs_valid_end} !== 2'b00)
      $display("FAIL asc_idle_at_done: got busy,valid=%b expected 00", {obs_busy_end, obs_valid_end}); else pass_cnt++;
    chk_cnt++; if (obs_done_cnt != 1) $display("FAIL asc_done_pulses: got %0d expected 1", obs_done_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    frame = asc_frame;
    start_frame();
    collect(1, 0);
    chk_cnt++; if (obs_data.size() != N) $display("FAIL bp_count: got %0d expected %0d", obs_data.size(), N); else pass_cnt++;
    for (int k = 0; k < obs_data.size(); k++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk_cnt++; if (obs_data[k] !== e || obs_idx[k] != k)
        $display("FAIL bp_data[%0d]: got %0d@%0d expected %0d@%0d", k, obs_data[k], obs_idx[k], e, k); else pass_cnt++;
    end
    chk_cnt++; if (obs_hold_viol != 0) $display("FAIL bp_hold: got %0d unstable stalls expected 0", obs_hold_viol); else pass_cnt++;
    chk_cnt++; if (obs_done_cnt != 1) $display("FAIL bp_done_pulses: got %0d expected 1", obs_done_cnt); else pass_cnt++;
  endtask

  task automatic test_unsorted();
    logic e;
    random_frame(1'b0);
    frame[0] = 8'd5; frame[1] = 8'd9; frame[2] = 8'd4;
    e = ref_err(1'b0);
    start_frame();
    chk_cnt++; if (order_err_a !== e) $display("FAIL uns_err: got %b expected %b", order_err_a, e); else pass_cnt++;
    collect(2, 0);
    chk_cnt++; if (obs_data.size() != N) $display("FAIL uns_count: got %0d expected %0d", obs_data.size(), N); else pass_cnt++;
    for (int k = 0; k < obs_data.size(); k++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      chk_cnt++; if (obs_data[k] !== x) $display("FAIL uns_data[%0d]: got %0d expected %0d", k, obs_data[k], x); else pass_cnt++;
    end
    random_frame(1'b1);
    e = ref_err(1'b0);
    start_frame();
    chk_cnt++; if (order_err_a !== e) $display("FAIL uns_recover_err: got %b expected %b", order_err_a, e); else pass_cnt++;
    collect(0, 0);
  endtask

  task automatic test_overrun();
    logic e;
    random_frame(1'b0);
    frame[0] = 8'd200; frame[1] = 8'd10;
    e = ref_err(1'b0);
    start_frame();
    for (int i = 0; i < N; i++) sorted_array[i] = '0;
    chk_cnt++; if (overrun_a !== 1'b0) $display("FAIL ovr_before: got %b expected 0", overrun_a); else pass_cnt++;
    collect(0, 3);
    chk_cnt++; if (overrun_a !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun_a); else pass_cnt++;
    chk_cnt++; if (order_err_a !== e) $display("FAIL ovr_err_kept: got %b expected %b", order_err_a, e); else pass_cnt++;
    chk_cnt++; if (obs_data.size() != N) $display("FAIL ovr_count: got %0d expected %0d", obs_data.size(), N); else pass_cnt++;
    for (int k = 0; k < obs_data.size(); k++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      chk_cnt++; if (obs_data[k] !== x) $display("FAIL ovr_data[%0d]: got %0d expected %0d", k, obs_data[k], x); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if ({busy_a, if_a.out_valid} !== 2'b00)
        $display("FAIL held_level[%0d]: got busy,valid=%b expected 00", i, {busy_a, if_a.out_valid}); else pass_cnt++;
      tick();
    end
    random_frame(1'b1);
    start_frame();
    chk_cnt++; if ({busy_a, if_a.out_index, overrun_a} !== {1'b1, IW'(0), 1'b1})
      $display("FAIL recapture: got busy=%b idx=%0d ovr=%b expected 1,0,1", busy_a, if_a.out_index, overrun_a); else pass_cnt++;
    collect(2, 0);
    for (int k = 0; k < obs_data.size(); k++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      chk_cnt++; if (obs_data[k] !== x) $display("FAIL recap_data[%0d]: got %0d expected %0d", k, obs_data[k], x); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    random_frame(1'b0);
    frame[3] = 8'd250; frame[4] = 8'd1;
    start_frame();
    if_a.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    sort_ready = 1'b0;
    tick();
    chk_cnt++; if ({if_a.out_valid, busy_a, overrun_a, done_a, order_err_a} !== 5'b0)
      $display("FAIL midrst_flags: got valid,busy,ovr,done,err=%b expected 00000",
               {if_a.out_valid, busy_a, overrun_a, done_a, order_err_a}); else pass_cnt++;
    chk_cnt++; if (if_a.out_index !== '0) $display("FAIL midrst_index: got %0d expected 0", if_a.out_index); else pass_cnt++;
    reset = 1'b0;
    tick();
    random_frame(1'b1);
    start_frame();
    collect(2, 0);
    chk_cnt++; if (obs_data.size() != N) $display("FAIL midrst_count: got %0d expected %0d", obs_data.size(), N); else pass_cnt++;
    for (int k = 0; k < obs_data.size(); k++) begin
      logic [W-1:0] x;
      x = exp_q.pop_front();
      chk_cnt++; if (obs_data[k] !== x || obs_idx[k] != k)
        $display("FAIL midrst_data[%0d]: got %0d@%0d expected %0d@%0d", k, obs_data[k], obs_idx[k], x, k); else pass_cnt++;
    end
  endtask

  task automatic test_descending();
    logic ea, ed;
    frame = desc_frame;
    ea = ref_err(1'b0);
    ed = ref_err(1'b1);
    start_frame();
    chk_cnt++; if (order_err_d !== ed) $display("FAIL desc_err_d: got %b expected %b", order_err_d, ed); else pass_cnt++;
    chk_cnt++; if (order_err_a !== ea) $display("FAIL desc_err_a: got %b expected %b", order_err_a, ea); else pass_cnt++;
    chk_cnt++; if (if_d.out_data !== desc_frame[0]) $display("FAIL desc_first: got %0d expected %0d", if_d.out_data, desc_frame[0]); else pass_cnt++;
    collect(0, 0);
    frame = asc_frame;
    ea = ref_err(1'b0);
    ed = ref_err(1'b1);
    start_frame();
    chk_cnt++; if (order_err_d !== ed) $display("FAIL asc_on_desc_err: got %b expected %b", order_err_d, ed); else pass_cnt++;
    chk_cnt++; if (order_err_a !== ea) $display("FAIL asc_on_asc_err: got %b expected %b", order_err_a, ea); else pass_cnt++;
    collect(0, 0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      logic e;
      random_frame(1'($urandom_range(0, 1)));
      e = ref_err(1'b0);
      start_frame();
      chk_cnt++; if (order_err_a !== e) $display("FAIL rnd%0d_err: got %b expected %b", f, order_err_a, e); else pass_cnt++;
      collect(2, 0);
      chk_cnt++; if (obs_data.size() != N || obs_hold_viol != 0)
        $display("FAIL rnd%0d_stream: got %0d transfers, %0d unstable stalls expected %0d, 0", f, obs_data.size(), obs_hold_viol, N); else pass_cnt++;
      for (int k = 0; k < obs_data.size(); k++) begin
        logic [W-1:0] x;
        x = exp_q.pop_front();
        chk_cnt++; if (obs_data[k] !== x) $display("FAIL rnd%0d_data[%0d]: got %0d expected %0d", f, k, obs_data[k], x); else pass_cnt++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    asc_frame  = '{8'd3, 8'd17, 8'd17, 8'd40, 8'd88, 8'd120, 8'd200, 8'd255};
    desc_frame = '{8'd255, 8'd200, 8'd120, 8'd88, 8'd40, 8'd17, 8'd17, 8'd3};
    test_reset();
    test_ascending();
    test_backpressure();
    test_unsorted();
    test_overrun();
    test_reset_mid_frame();
    test_descending();
    test_random_frames();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
